// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-port SRAM arbiter: FSM state codes, port
// indices and default bus widths.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_XFER = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic P_CPU  = 1'b0;
  localparam logic P_HOST = 1'b1;

  function automatic int burst_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between the two requesters, honouring the
// burst cap in round-robin mode or fixed priority to port 0.
module arb_pick2
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter bit RR_EN     = 1'b1,
  parameter int BW        = 3
) (
  input  logic          req0,
  input  logic          req1,
  input  logic          owner,
  input  logic [BW-1:0] burst_cnt,
  output logic          any,
  output logic          winner
);

  localparam logic [BW-1:0] CAP = BW'(MAX_BURST);

  logic keep;

  // burst_cnt == 0 means nobody has been served yet, so the tie goes to the
  // port opposite the reset owner (port 0).
  always_comb begin
    keep   = (burst_cnt != '0) && (burst_cnt < CAP);
    any    = req0 | req1;
    winner = P_CPU;
    if (req0 && req1) begin
      if (RR_EN) winner = keep ? owner : ~owner;
      else       winner = P_CPU;
    end else if (req1) begin
      winner = P_HOST;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between a CPU port and a host/DMA port; each
// access is a single byte with req/ack handshake, IDLE -> XFER -> DONE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int MAX_BURST = 4,
  parameter bit RR_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [WORD_SIZE-1:0] wdata0,
  output logic                 gnt0,
  output logic                 ack0,
  output logic [WORD_SIZE-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt1,
  output logic                 ack1,
  output logic [WORD_SIZE-1:0] rdata1,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [1:0]           state
);

  // Handshake: a requester raises req with we/addr/wdata and holds them until
  // it sees ack (one cycle); it may change them only on the edge ending ack.

  localparam int            BW  = burst_width(MAX_BURST);
  localparam logic [BW-1:0] CAP = BW'(MAX_BURST);

  logic          owner;
  logic [BW-1:0] burst_cnt;
  logic          any;
  logic          winner;

  arb_pick2 #(
    .MAX_BURST(MAX_BURST),
    .RR_EN    (RR_EN),
    .BW       (BW)
  ) u_pick (
    .req0     (req0),
    .req1     (req1),
    .owner    (owner),
    .burst_cnt(burst_cnt),
    .any      (any),
    .winner   (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      owner     <= P_HOST;
      burst_cnt <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            if (winner == P_HOST) begin
              mem_addr  <= addr1;
              mem_wdata <= wdata1;
              mem_write <= we1;
              gnt1      <= 1'b1;
            end else begin
              mem_addr  <= addr0;
              mem_wdata <= wdata0;
              mem_write <= we0;
              gnt0      <= 1'b1;
            end
            if (winner == owner)
              burst_cnt <= (burst_cnt >= CAP) ? CAP : burst_cnt + 1'b1;
            else
              burst_cnt <= BW'(1);
            owner <= winner;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          // The SRAM commits a write on this same edge; reads capture here.
          if (!mem_write) begin
            if (owner == P_HOST) rdata1 <= mem_rdata;
            else                 rdata0 <= mem_rdata;
          end
          mem_write <= 1'b0;
          if (owner == P_HOST) ack1 <= 1'b1;
          else                 ack0 <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          mem_write <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset abort, burst-cap
// ordering, random traffic against a memory model, fixed-priority instance.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0, we0, req1, we1;
  logic [7:0]   addr0, wdata0, addr1, wdata1;
  logic         gnt0, ack0, gnt1, ack1, mem_write;
  logic [7:0]   rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]   state;

  logic         f_req0, f_we0, f_req1, f_we1;
  logic [7:0]   f_addr0, f_wdata0, f_addr1, f_wdata1;
  logic         f_gnt0, f_ack0, f_gnt1, f_ack1, f_mem_write;
  logic [7:0]   f_rdata0, f_rdata1, f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic [1:0]   f_state;

  mem_port_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .MAX_BURST(4), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .state(state)
  );

  mem_port_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .MAX_BURST(4), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst_n),
    .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0),
    .gnt0(f_gnt0), .ack0(f_ack0), .rdata0(f_rdata0),
    .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1),
    .gnt1(f_gnt1), .ack1(f_ack1), .rdata1(f_rdata1),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_write(f_mem_write),
    .mem_rdata(f_mem_rdata), .state(f_state)
  );

  // SRAM environment: loads a known pattern on the first clock, then writes
  // on posedge when strobed; reads are combinational.
  logic [7:0] sram [256];
  logic       sram_ready = 1'b0;
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 256; i++) sram[i] <= 8'(i) ^ 8'hA5;
      sram_ready <= 1'b1;
    end else if (mem_write) begin
      sram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata   = sram[mem_addr];
  assign f_mem_rdata = f_mem_addr ^ 8'h3C;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] ref_mem [256];
  logic [W-1:0] exp_q[$];
  int         ack_log[$];
  int         n_ack [2];
  int         remaining [2];
  int         prob;
  int         wr_pulses = 0;
  logic       prev_mw = 1'b0;
  logic [7:0] last_rd [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic handle_ack(input int p);
    logic       we, gnt;
    logic [7:0] a, d, rd;
    we  = (p == 0) ? we0 : we1;
    gnt = (p == 0) ? gnt0 : gnt1;
    a   = (p == 0) ? addr0 : addr1;
    d   = (p == 0) ? wdata0 : wdata1;
    rd  = (p == 0) ? rdata0 : rdata1;
    n_ack[p]++;
    ack_log.push_back(p);
    check($sformatf("gnt_with_ack%0d", p), 64'(gnt), 64'd1);
    if (we) ref_mem[a] = d;
    else    check($sformatf("rdata%0d_addr%0h", p, a), 64'(rd), 64'(ref_mem[a]));
  endtask

  task automatic monitor();
    if (rst_n) begin
      check("gnt_overlap", 64'(gnt0 & gnt1), 64'd0);
      check("ack_overlap", 64'(ack0 & ack1), 64'd0);
      if (mem_write) begin
        check("mem_write_pulse", 64'(prev_mw), 64'd0);
        check("mem_write_on_write", 64'(gnt0 ? we0 : (gnt1 ? we1 : 1'b0)), 64'd1);
        wr_pulses++;
      end
      prev_mw = mem_write;
      if (ack0) handle_ack(0);
      if (ack1) handle_ack(1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic set_req(input int p, input logic r, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic auto_step(input int p);
    logic r, a;
    r = (p == 0) ? req0 : req1;
    a = (p == 0) ? ack0 : ack1;
    if (a || !r) begin
      if (remaining[p] > 0 && $urandom_range(99) < prob) begin
        remaining[p]--;
        set_req(p, 1'b1, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
      end else begin
        set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
      end
    end
  endtask

  task automatic single_txn(input int p, input logic we, input logic [7:0] a,
                            input logic [7:0] d, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    set_req(p, 1'b1, we, a, d);
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      lat++;
      seen = (p == 0) ? ack0 : ack1;
    end
    if (!seen) lat = 99;
    set_req(p, 1'b0, we, a, d);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int   lat, p0, a0, a1, cyc;
    logic seen;

    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    {f_req0, f_we0, f_addr0, f_wdata0} = '0;
    {f_req1, f_we1, f_addr1, f_wdata1} = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    n_ack[0] = 0;
    n_ack[1] = 0;

    // Reset held with random inputs: every output stays at zero.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_req(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      set_req(1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      {f_req0, f_we0, f_req1, f_we1} = 4'($urandom);
    end
    check("reset_outputs", 64'({gnt0, gnt1, ack0, ack1, mem_write, mem_addr,
                                mem_wdata, rdata0, rdata1, state}), 64'd0);
    check("reset_outputs_fp", 64'({f_gnt0, f_gnt1, f_ack0, f_ack1, f_mem_write, f_mem_addr,
                                   f_mem_wdata, f_rdata0, f_rdata1, f_state}), 64'd0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    {f_req0, f_we0, f_req1, f_we1} = '0;
    rst_n = 1'b1;
    tick();
    tick();

    vecs[0] = '{1'b1, 1'b1, 8'h20, 8'h5C, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h5C};
    vecs[2] = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h01};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hFE, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hFE};
    vecs[6] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h5C};
    vecs[7] = '{1'b1, 1'b1, 8'h80, 8'h7F, 8'h00};
    vecs[8] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h7F};
    vecs[9] = '{1'b1, 1'b0, 8'h40, 8'h00, 8'hE5};

    for (int i = 0; i < 10; i++) begin
      p0 = wr_pulses;
      single_txn(int'(vecs[i].port), vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_write_pulses", i), 64'(wr_pulses - p0), 64'(vecs[i].we));
      if (!vecs[i].we) last_rd[vecs[i].port] = vecs[i].exp_rdata;
      check($sformatf("vec%0d_rdata0_held", i), 64'(rdata0), 64'(last_rd[0]));
      check($sformatf("vec%0d_rdata1_held", i), 64'(rdata1), 64'(last_rd[1]));
    end

    // Reset during XFER of a write aborts it before the SRAM commits.
    a0 = n_ack[0];
    set_req(0, 1'b1, 1'b1, 8'h10, 8'hAA);
    tick();
    check("abort_mem_write_before", 64'(mem_write), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_write_drop", 64'(mem_write), 64'd0);
    check("abort_gnt0", 64'(gnt0), 64'd0);
    check("abort_state", 64'(state), 64'(S_IDLE));
    tick();
    tick();
    check("abort_sram_unchanged", 64'(sram[8'h10]), 64'h10 ^ 64'hA5);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    prev_mw = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_no_ack", 64'(n_ack[0] - a0), 64'd0);

    // Both ports request together from reset: burst-capped alternation.
    for (int i = 0; i < 16; i++) exp_q.push_back(W'((i / 4) % 2));
    ack_log.delete();
    a0 = n_ack[0];
    a1 = n_ack[1];
    remaining[0] = 8;
    remaining[1] = 8;
    prob = 100;
    auto_step(0);
    auto_step(1);
    for (int i = 0; i < 48; i++) begin
      tick();
      auto_step(0);
      auto_step(1);
    end
    check("burst_acks0", 64'(n_ack[0] - a0), 64'd8);
    check("burst_acks1", 64'(n_ack[1] - a1), 64'd8);
    check("burst_log_size", 64'(ack_log.size()), 64'd16);
    for (int i = 0; i < 16 && exp_q.size() > 0; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      if (i < ack_log.size()) check($sformatf("burst_order%0d", i), 64'(ack_log[i]), 64'(e));
    end
    tick();
    tick();

    // Random traffic on both ports, data checked against the memory model.
    a0 = n_ack[0];
    a1 = n_ack[1];
    remaining[0] = 40;
    remaining[1] = 40;
    prob = 50;
    cyc = 0;
    while ((remaining[0] > 0 || remaining[1] > 0 || req0 || req1) && cyc < 3000) begin
      tick();
      auto_step(0);
      auto_step(1);
      cyc++;
    end
    check("random_finished", 64'(cyc < 3000), 64'd1);
    check("random_acks0", 64'(n_ack[0] - a0), 64'd40);
    check("random_acks1", 64'(n_ack[1] - a1), 64'd40);
    tick();
    tick();

    // Requester drops req mid-transfer; the write still lands and acks once.
    a0 = n_ack[0];
    set_req(0, 1'b1, 1'b1, 8'h33, 8'h99);
    tick();
    req0 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("drop_ack_once", 64'(n_ack[0] - a0), 64'd1);
    check("drop_write_landed", 64'(sram[8'h33]), 64'h99);

    // Fixed priority: port 1 starves while port 0 requests.
    a0 = 0;
    a1 = 0;
    {f_req0, f_we0, f_addr0, f_wdata0} = {1'b1, 1'b1, 8'h05, 8'h11};
    {f_req1, f_we1, f_addr1, f_wdata1} = {1'b1, 1'b0, 8'h06, 8'h00};
    for (int i = 0; i < 29; i++) begin
      tick();
      check("fp_gnt_overlap", 64'(f_gnt0 & f_gnt1), 64'd0);
      if (f_ack0) a0++;
      if (f_ack1) a1++;
    end
    check("fp_acks0", 64'(a0), 64'd10);
    check("fp_acks1_starved", 64'(a1), 64'd0);
    check("fp_last_cycle_ack0", 64'(f_ack0), 64'd1);
    f_req0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick();
      seen = f_ack1;
    end
    check("fp_port1_served", 64'(seen), 64'd1);
    check("fp_port1_rdata", 64'(f_rdata1), 64'h06 ^ 64'h3C);
    f_req1 = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
